rr_arb_mux_4_1: RTL and testbench
=================================

// Module: rr_arb_mux_4_1
// PURPOSE
//  Round-robin arbiter sharing one registered output channel between four
//  valid/ready requesters; drives the select of a 4:1 data mux.
//  Sits in front of any single-consumer datapath fed by four producers.
//  Guarantees fairness: a continuously requesting source waits at most 3 grants.
// PARAMETERS
//  WIDTH   4   data width of each requester and of out_data
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   4        per-requester valid, bit i = source i
//  in_ready   out  4        per-requester ready, at most one bit set (one-hot or 0)
//  d0..d3     in   WIDTH    requester data, sampled when in_valid[i] & in_ready[i]
//  out_valid  out  1        output register holds a transfer
//  out_ready  in   1        consumer accepts when out_valid & out_ready
//  out_data   out  WIDTH    registered selected data
//  out_sel    out  2        index of source that produced out_data
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=0.
//  ptr[1:0]: highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  grant = first i in search order with in_valid[i]; none -> no grant.
//  can_load = !out_valid | out_ready (combinational).
//  in_ready[i] = grant[i] & can_load; in_ready never asserted while rst=1.
//  On edge with in_valid[g] & in_ready[g]: out_data<=d_g (via 4:1 mux, sel=g),
//   out_sel<=g, out_valid<=1, ptr<=g+1 (wraps 3->0).
//  On edge with out_valid & out_ready and no new load: out_valid<=0; data/sel hold.
//  Simultaneous drain + load: both in same cycle -> out_valid stays 1, new data.
//   Throughput 1 transfer/cycle when out_ready=1; latency in->out = 1 cycle.
//  Backpressure: out_valid=1 & out_ready=0 -> out_data/out_sel/out_valid stable,
//   in_ready=0, ptr unchanged.
//  Grant is combinational per cycle (not locked): a source dropping in_valid
//   before acceptance loses its turn without penalty; ptr moves only on accept.
//  No requests: ptr unchanged, no state change.
//  Reset mid-transfer: pending output discarded, ptr back to 0.
//  out_sel, out_data are don't-care to consumer when out_valid=0 but hold last value.
// STRUCTURE
//  Package arb_pkg: localparam N_REQ=4; typedef logic [1:0] req_idx_t;
//   typedef logic [3:0] req_vec_t.
//  Sub-module rr_pick_4: comb, inputs req_vec_t req, req_idx_t ptr;
//   outputs gnt_valid, req_idx_t gnt_idx (rotate, priority-encode, unrotate).
//  Data selection reuses mux_4_1 pattern (two-level sel[1]/sel[0]) at WIDTH.
//  Top holds ptr, out regs, ready logic.
// TESTING
//  1 Reset: rst=1 mid-run with out_valid=1 -> out_valid=0, out_sel=0, in_ready=0
//    immediately (before next clk edge).
//  2 Single source: in_valid=4'b0100, d2=9, out_ready=1 -> in_ready=4'b0100;
//    next cycle out_valid=1, out_data=9, out_sel=2; ptr=3.
//  3 All request, out_ready=1, from reset: out_sel sequence 0,1,2,3,0 on
//    consecutive cycles, out_valid=1 each cycle, in_ready one-hot each cycle.
//  4 Backpressure: out_valid=1, out_data=5, out_ready=0 for 3 cycles with
//    in_valid=4'b1111 -> in_ready=0, out_data=5, out_sel unchanged all 3 cycles.
//  5 Wrap: ptr=3, in_valid=4'b1001 -> grant 3 first (out_sel=3), then 0.
//  6 Withdrawal: in_valid=4'b0010 with out_ready=0, then drop to 4'b0001 before
//    accept -> accepted source is 0, out_sel=0, ptr=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter and its output mux.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;
    typedef logic [3:0] req_vec_t;

    // Index following idx in the circular search order (3 wraps to 0).
    function automatic req_idx_t next_idx(input req_idx_t idx);
        return req_idx_t'(idx + 2'd1);
    endfunction

    // One-hot vector with only bit idx set.
    function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
        return req_vec_t'(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/rr_arb_mux_4_1_pick.sv
// Combinational round-robin pick: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then rotate the result back to an absolute index.
module rr_pick_4
    import arb_pkg::*;
(
    input  req_vec_t req,
    input  req_idx_t ptr,
    output logic     gnt_valid,
    output req_idx_t gnt_idx
);

    logic [2*N_REQ-1:0] req_dbl;
    req_vec_t           req_rot;
    req_idx_t           rot_off;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rot_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = req_idx_t'(i);
            end
        end
    end

    assign gnt_valid = |req;
    assign gnt_idx   = req_idx_t'(ptr + rot_off);

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Four requesters share one registered valid/ready output channel; a round-robin
// pointer picks the source and drives the select of a 4:1 data mux.
module rr_arb_mux_4_1
    import arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    req_idx_t         ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    req_idx_t         out_sel_q, out_sel_d;

    logic             gnt_valid;
    req_idx_t         gnt_idx;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] mux_lo, mux_hi, mux_data;

    rr_pick_4 u_pick (
        .req       (req_vec_t'(in_valid)),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Two-level 4:1 mux: sel[0] picks within each pair, sel[1] picks the pair.
    assign mux_lo   = gnt_idx[0] ? d1 : d0;
    assign mux_hi   = gnt_idx[0] ? d3 : d2;
    assign mux_data = gnt_idx[1] ? mux_hi : mux_lo;

    // The output slot is free when empty or being drained this cycle.
    assign can_load = !out_valid_q || out_ready;

    // Reset clears out_valid asynchronously, which would open can_load; rst gates it shut.
    assign load     = gnt_valid && can_load && !rst;
    assign in_ready = load ? idx_to_onehot(gnt_idx) : '0;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_data_d  = mux_data;
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = next_idx(gnt_idx);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed self-checking bench for rr_arb_mux_4_1: reset, single source, rotation,
// backpressure, pointer wrap and request withdrawal, with hand-computed expectations.
module tb_rr_arb_mux_4_1;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    int n_checks = 0;
    int n_errors = 0;

    rr_arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] sel,
                             input logic [WIDTH-1:0] data);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".out_sel"},   32'(out_sel),   32'(sel));
        check({tag, ".out_data"},  32'(out_data),  32'(data));
    endtask

    logic [1:0] exp_sel;
    logic [WIDTH-1:0] exp_data [4];

    initial begin
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (2) tick();
        check_out("reset", 1'b0, 2'd0, 4'd0);
        check("reset.in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;

        // Single source 2 from ptr=0.
        in_valid = 4'b0100; d2 = 4'd9; out_ready = 1'b1;
        #1;
        check("single.in_ready", 32'(in_ready), 32'b0100);
        tick();
        check_out("single", 1'b1, 2'd2, 4'd9);

        // Wrap: ptr is now 3, sources 3 and 0 request.
        in_valid = 4'b1001; d3 = 4'd3; d0 = 4'hA;
        #1;
        check("wrap.in_ready0", 32'(in_ready), 32'b1000);
        tick();
        check_out("wrap.first", 1'b1, 2'd3, 4'd3);
        check("wrap.in_ready1", 32'(in_ready), 32'b0001);
        tick();
        check_out("wrap.second", 1'b1, 2'd0, 4'hA);

        // Reset mid-run while holding a transfer; effect must be immediate.
        in_valid = 4'b1111;
        rst = 1'b1;
        #1;
        check_out("midrst", 1'b0, 2'd0, 4'd0);
        check("midrst.in_ready", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b0;

        // All request from reset: rotation 0,1,2,3,0.
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        exp_data[0] = 4'd1; exp_data[1] = 4'd2; exp_data[2] = 4'd3; exp_data[3] = 4'd4;
        in_valid = 4'b1111; out_ready = 1'b1;
        exp_sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr%0d.in_ready", i), 32'(in_ready), 32'(4'b0001 << exp_sel));
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, exp_sel, exp_data[exp_sel]);
            exp_sel = exp_sel + 2'd1;
        end

        // ptr=1: load source 1 with data 5, then hold output under backpressure.
        d1 = 4'd5;
        #1;
        check("bp.load.in_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("bp.load", 1'b1, 2'd1, 4'd5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
            tick();
            check_out($sformatf("bp%0d", i), 1'b1, 2'd1, 4'd5);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 32'(in_ready), 32'b0100);

        // Drain with no requests: valid drops, data and sel hold.
        in_valid = 4'b0000;
        #1;
        check("drain.in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("drain", 1'b0, 2'd1, 4'd5);

        // Withdrawal: fill from source 2 (ptr=2 -> 3), block, then 1 withdraws for 0.
        in_valid = 4'b0100; d2 = 4'd7;
        tick();
        check_out("wd.fill", 1'b1, 2'd2, 4'd7);
        out_ready = 1'b0; in_valid = 4'b0010;
        #1;
        check("wd.blocked.in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("wd.blocked", 1'b1, 2'd2, 4'd7);
        in_valid = 4'b0001; out_ready = 1'b1; d0 = 4'hC;
        #1;
        check("wd.swap.in_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("wd.accept", 1'b1, 2'd0, 4'hC);
        in_valid = 4'b1111;
        #1;
        check("wd.ptr1.in_ready", 32'(in_ready), 32'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
